// File: rtl/decoder_pkg.sv
// Shared widths and types for the registered 8-to-256 one-hot decoder.
package decoder_pkg;

  localparam int DEC_ADDR_W = 8;
  localparam int DEC_OUT_W  = 256;
  localparam int PREDEC_W   = 16;

  typedef logic [DEC_ADDR_W-1:0] dec_addr_t;
  typedef logic [DEC_OUT_W-1:0]  dec_onehot_t;

endpackage

// File: rtl/decoder_4to16.sv
// Combinational predecoder: binary select to one-hot vector.
module decoder_4to16 #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_8_to_256.sv
// Registered binary to one-hot decoder built from two predecoders.
// Optional sticky one-hot checker under DECODER_ONEHOT_CHECK_EN.
module decoder_8_to_256
  import decoder_pkg::*;
#(
  parameter int ADDR_W = DEC_ADDR_W,
  parameter int OUT_W  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] address,
  output logic [OUT_W-1:0]  decoded_output,
`ifdef DECODER_ONEHOT_CHECK_EN
  output logic              onehot_err,
`endif
  output logic              valid_out
);

  localparam int HALF_W = ADDR_W / 2;
  localparam int PW     = 2**HALF_W;

  logic [PW-1:0]    ph;
  logic [PW-1:0]    pl;
  logic [OUT_W-1:0] next_out;

  decoder_4to16 #(.IN_W(HALF_W)) u_pre_hi (
    .sel    (address[ADDR_W-1:HALF_W]),
    .onehot (ph)
  );

  decoder_4to16 #(.IN_W(HALF_W)) u_pre_lo (
    .sel    (address[HALF_W-1:0]),
    .onehot (pl)
  );

  for (genvar j = 0; j < PW; j++) begin : g_row
    for (genvar k = 0; k < PW; k++) begin : g_col
      assign next_out[j*PW+k] = ph[j] & pl[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_output <= '0;
      valid_out      <= 1'b0;
    end else if (en) begin
      decoded_output <= next_out;
      valid_out      <= 1'b1;
    end
  end

`ifdef DECODER_ONEHOT_CHECK_EN
  // Flags any registered word that is not exactly one-hot once loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_err <= 1'b0;
    end else if (valid_out && ($countones(decoded_output) != 1)) begin
      onehot_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_8_to_256.sv
// Directed plus randomized checks of decoder_8_to_256 against a shift model.
module tb_decoder_8_to_256;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   address;
  logic [255:0] decoded_output;
  logic         valid_out;
`ifdef DECODER_ONEHOT_CHECK_EN
  logic         onehot_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [255:0] exp_out;
  logic         exp_valid;

  always #5 clk = ~clk;

  decoder_8_to_256 dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .address        (address),
    .decoded_output (decoded_output),
`ifdef DECODER_ONEHOT_CHECK_EN
    .onehot_err     (onehot_err),
`endif
    .valid_out      (valid_out)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, decoded_output, exp_out);
    chk({tag, ".valid"}, {255'd0, valid_out}, {255'd0, exp_valid});
    if (exp_valid)
      chk({tag, ".pop"}, 256'($countones(decoded_output)), 256'd1);
`ifdef DECODER_ONEHOT_CHECK_EN
    chk({tag, ".err"}, {255'd0, onehot_err}, 256'd0);
`endif
  endtask

  // Drive on the falling edge, model the rising edge, check on the next fall.
  task automatic step(input logic e, input logic [7:0] a, input string tag);
    en      = e;
    address = a;
    @(posedge clk);
    if (e) begin
      exp_out   = 256'd1 << a;
      exp_valid = 1'b1;
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    address   = '0;
    exp_out   = '0;
    exp_valid = 1'b0;
    #3;
    chk_all("reset_no_clk");
    en      = 1'b1;
    address = 8'd9;
    @(posedge clk);
    @(negedge clk);
    chk_all("reset_held");
    rst = 1'b0;

    step(1'b1, 8'b0000_0101, "addr5");
    chk("addr5_val", decoded_output, 256'h20);
    step(1'b1, 8'b1000_0010, "addr130");
    step(1'b1, 8'd0, "b2b_0");
    step(1'b1, 8'd255, "b2b_255");
    step(1'b1, 8'd37, "load37");
    for (int i = 0; i < 5; i++) step(1'b0, 8'd200, "hold37");

    #2 rst = 1'b1;
    exp_out   = '0;
    exp_valid = 1'b0;
    #1;
    chk_all("async_clear");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'd77, "post_rst_idle");
    step(1'b1, 8'd77, "fresh_load");

    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), "sweep");

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
